// File: rtl/mem_arbiter_if.sv
// Bundles the CPU, loader and RAM-side signals of the program/data RAM arbiter.
// The slave modport is the arbiter's view. The master modport is the requester/RAM side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_stall;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_hold;
  logic              ld_gnt;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_rvalid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_hold,
    input  mem_rdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid, cpu_stall,
    output ld_gnt, ld_rdata, ld_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ld_req, ld_we, ld_addr, ld_wdata, ld_hold,
    output mem_rdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid, cpu_stall,
    input  ld_gnt, ld_rdata, ld_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port RAM between the CPU and the program loader.
// The loader can claim exclusive ownership, which stalls the CPU sequencer.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StRun, StDrain, StExcl} state_e;

  state_e            state_q, state_d;
  logic              last_ld_q, last_ld_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              ld_gnt_q, ld_gnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              ld_rvalid_q, ld_rvalid_d;
  logic              cpu_stall_q, cpu_stall_d;
  // Read-owner tags: stage 1 covers the strobe cycle, stage 2 the RAM response cycle.
  logic              tag1_vld_q, tag1_vld_d, tag1_ld_q, tag1_ld_d;
  logic              tag2_vld_q, tag2_ld_q;

  logic cpu_rd_pending;
  logic cpu_elig, ld_elig;
  logic grant_cpu, grant_ld;

  assign cpu_rd_pending = (tag1_vld_q && !tag1_ld_q) || (tag2_vld_q && !tag2_ld_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (bus.ld_hold) state_d = cpu_rd_pending ? StDrain : StExcl;
      end
      StDrain: begin
        if (!bus.ld_hold)        state_d = StRun;
        else if (!cpu_rd_pending) state_d = StExcl;
      end
      StExcl: begin
        if (!bus.ld_hold) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // CPU may only win when the edge leaves us in RUN; a granted requester sits out one decision.
  always_comb begin
    cpu_elig  = bus.cpu_req && !cpu_gnt_q && (state_d == StRun);
    ld_elig   = bus.ld_req && !ld_gnt_q;
    grant_cpu = cpu_elig && (!ld_elig || last_ld_q);
    grant_ld  = ld_elig && !grant_cpu;
  end

  always_comb begin
    last_ld_d   = last_ld_q;
    cpu_gnt_d   = grant_cpu;
    ld_gnt_d    = grant_ld;
    mem_en_d    = grant_cpu || grant_ld;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    tag1_vld_d  = 1'b0;
    tag1_ld_d   = 1'b0;
    if (grant_cpu) begin
      last_ld_d   = 1'b0;
      mem_we_d    = bus.cpu_we;
      mem_addr_d  = bus.cpu_addr;
      mem_wdata_d = bus.cpu_wdata;
      tag1_vld_d  = !bus.cpu_we;
    end else if (grant_ld) begin
      last_ld_d   = 1'b1;
      mem_we_d    = bus.ld_we;
      mem_addr_d  = bus.ld_addr;
      mem_wdata_d = bus.ld_wdata;
      tag1_vld_d  = !bus.ld_we;
      tag1_ld_d   = 1'b1;
    end
  end

  always_comb begin
    cpu_rdata_d  = cpu_rdata_q;
    cpu_rvalid_d = 1'b0;
    ld_rdata_d   = ld_rdata_q;
    ld_rvalid_d  = 1'b0;
    if (tag2_vld_q) begin
      if (tag2_ld_q) begin
        ld_rdata_d  = bus.mem_rdata;
        ld_rvalid_d = 1'b1;
      end else begin
        cpu_rdata_d  = bus.mem_rdata;
        cpu_rvalid_d = 1'b1;
      end
    end
    cpu_stall_d = (state_d != StRun);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      last_ld_q    <= 1'b1;
      cpu_gnt_q    <= 1'b0;
      ld_gnt_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      ld_rdata_q   <= '0;
      ld_rvalid_q  <= 1'b0;
      cpu_stall_q  <= 1'b0;
      tag1_vld_q   <= 1'b0;
      tag1_ld_q    <= 1'b0;
      tag2_vld_q   <= 1'b0;
      tag2_ld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_ld_q    <= last_ld_d;
      cpu_gnt_q    <= cpu_gnt_d;
      ld_gnt_q     <= ld_gnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ld_rdata_q   <= ld_rdata_d;
      ld_rvalid_q  <= ld_rvalid_d;
      cpu_stall_q  <= cpu_stall_d;
      tag1_vld_q   <= tag1_vld_d;
      tag1_ld_q    <= tag1_ld_d;
      tag2_vld_q   <= tag1_vld_q;
      tag2_ld_q    <= tag1_ld_q;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_stall  = cpu_stall_q;
  assign bus.ld_gnt     = ld_gnt_q;
  assign bus.ld_rdata   = ld_rdata_q;
  assign bus.ld_rvalid  = ld_rvalid_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule
